// File: rtl/down_counter_pkg.sv
// down_counter_pkg: shared state encoding and default width for down_counter
package down_counter_pkg;
  localparam int DC_DEFAULT_WIDTH = 8;
  typedef enum logic [1:0] {IDLE, COUNT, DONE} dc_state_t;
endpackage

// File: rtl/down_counter.sv
// down_counter: loadable down counter with one-cycle terminal-count pulse and optional auto-reload
module down_counter
  import down_counter_pkg::*;
#(
  parameter int WIDTH = DC_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             tc,
  output logic             busy
);
  dc_state_t        state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d, reload_q, reload_d;
  logic             tc_q, tc_d, busy_q, busy_d;
  logic             last;
  assign last = cnt_q <= WIDTH'(1);
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (load) begin
      cnt_d    = in;
      reload_d = in;
      state_d  = (in != '0) ? COUNT : IDLE;
    end else if (state_q == COUNT && enable) begin
      cnt_d   = last ? '0 : cnt_q - WIDTH'(1);
      tc_d    = last;
      state_d = last ? DONE : COUNT;
    end else if (state_q == DONE && enable && auto_reload) begin
      cnt_d   = reload_q;
      state_d = COUNT;
    end
    busy_d = state_d == COUNT;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      busy_q   <= busy_d;
    end
  end
  assign out  = cnt_q;
  assign zero = cnt_q == '0;
  assign tc   = tc_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_down_counter.sv
// tb_down_counter: directed table plus hand sequences for down_counter
module tb_down_counter;
  logic       clk = 1'b0;
  logic       reset, enable, load, auto_reload;
  logic [7:0] din, dout;
  logic       zero, tc, busy;
  int         checks = 0, failures = 0;

  typedef struct {
    logic       rst, ld;
    logic [7:0] din;
    logic       en, ar;
    logic [7:0] eo;
    logic       ez, et, eb;
  } vec_t;

  vec_t vecs[19];

  down_counter #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .in(din),
    .auto_reload(auto_reload), .out(dout), .zero(zero), .tc(tc), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic rst, logic ld, logic [7:0] d, logic en, logic ar,
                              logic [7:0] eo, logic ez, logic et, logic eb);
    vec_t v;
    v.rst = rst; v.ld = ld; v.din = d; v.en = en; v.ar = ar;
    v.eo = eo; v.ez = ez; v.et = et; v.eb = eb;
    return v;
  endfunction

  task automatic drive(input logic rst, input logic ld, input logic [7:0] d,
                       input logic en, input logic ar);
    reset = rst; load = ld; din = d; enable = en; auto_reload = ar;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] eo, input logic ez,
                       input logic et, input logic eb);
    checks++;
    if (dout !== eo || zero !== ez || tc !== et || busy !== eb) begin
      failures++;
      $display("FAIL %s: got out=%h zero=%b tc=%b busy=%b, expected out=%h zero=%b tc=%b busy=%b",
               name, dout, zero, tc, busy, eo, ez, et, eb);
    end
  endtask

  initial begin
    vecs[0]  = mk(0, 1, 8'hFA, 1, 0, 8'h00, 1, 0, 0);
    vecs[1]  = mk(0, 0, 8'hFA, 1, 0, 8'h00, 1, 0, 0);
    vecs[2]  = mk(1, 0, 8'hFA, 1, 0, 8'h00, 1, 0, 0);
    vecs[3]  = mk(1, 0, 8'hFA, 1, 1, 8'h00, 1, 0, 0);
    vecs[4]  = mk(1, 1, 8'h02, 1, 0, 8'h02, 0, 0, 1);
    vecs[5]  = mk(1, 0, 8'h00, 1, 0, 8'h01, 0, 0, 1);
    vecs[6]  = mk(1, 1, 8'hFA, 1, 0, 8'hFA, 0, 0, 1);
    vecs[7]  = mk(1, 0, 8'h00, 0, 0, 8'hFA, 0, 0, 1);
    vecs[8]  = mk(1, 1, 8'h00, 1, 0, 8'h00, 1, 0, 0);
    vecs[9]  = mk(1, 0, 8'h00, 1, 1, 8'h00, 1, 0, 0);
    vecs[10] = mk(1, 1, 8'h05, 0, 0, 8'h05, 0, 0, 1);
    vecs[11] = mk(1, 0, 8'h00, 1, 0, 8'h04, 0, 0, 1);
    vecs[12] = mk(1, 0, 8'h00, 1, 0, 8'h03, 0, 0, 1);
    vecs[13] = mk(1, 0, 8'h00, 1, 0, 8'h02, 0, 0, 1);
    vecs[14] = mk(1, 0, 8'h00, 1, 0, 8'h01, 0, 0, 1);
    vecs[15] = mk(1, 0, 8'h00, 1, 0, 8'h00, 1, 1, 0);
    vecs[16] = mk(1, 0, 8'h00, 1, 0, 8'h00, 1, 0, 0);
    vecs[17] = mk(1, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0);
    vecs[18] = mk(1, 0, 8'h00, 1, 0, 8'h00, 1, 0, 0);
    drive(0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].rst, vecs[i].ld, vecs[i].din, vecs[i].en, vecs[i].ar);
      step();
      check($sformatf("table[%0d]", i), vecs[i].eo, vecs[i].ez, vecs[i].et, vecs[i].eb);
    end
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 8'h00, 1, 0);
      step();
      check($sformatf("done_hold[%0d]", i), 8'h00, 1, 0, 0);
    end
    drive(1, 1, 8'h0A, 1, 0);
    step();
    check("gap_load", 8'h0A, 0, 0, 1);
    for (int i = 1; i <= 13; i++) begin
      logic [7:0] e;
      drive(1, 0, 8'h00, !(i >= 4 && i <= 6), 0);
      step();
      e = (i <= 3) ? 8'(10 - i) : (i <= 6) ? 8'd7 : 8'(13 - i);
      check($sformatf("gap[%0d]", i), e, i == 13, i == 13, i != 13);
    end
    drive(1, 1, 8'h03, 1, 1);
    step();
    check("ar_load", 8'h03, 0, 0, 1);
    for (int i = 1; i <= 12; i++) begin
      logic [7:0] e;
      drive(1, 0, 8'h00, 1, 1);
      step();
      e = 8'(3 - (i % 4));
      check($sformatf("auto_reload[%0d]", i), e, e == 0, e == 0, e != 0);
    end
    drive(1, 1, 8'hFF, 1, 0);
    step();
    check("mid_load", 8'hFF, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 8'h00, 1, 0);
      step();
    end
    check("mid_count20", 8'hEB, 0, 0, 1);
    drive(0, 0, 8'h00, 1, 0);
    step();
    check("mid_reset", 8'h00, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 8'h00, 1, 1);
      step();
      check($sformatf("post_reset_idle[%0d]", i), 8'h00, 1, 0, 0);
    end
    drive(1, 1, 8'h02, 1, 0);
    step();
    check("reload_after_reset", 8'h02, 0, 0, 1);
    drive(1, 0, 8'h00, 1, 0);
    step();
    check("resume1", 8'h01, 0, 0, 1);
    step();
    check("resume0", 8'h00, 1, 1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/down_counter.md
# down_counter

Loadable down counter and terminal-count generator; the decrementing counterpart of `up_counter`. It loads a start value, counts toward zero while enabled, and flags arrival at zero with a one-cycle terminal-count pulse. Optional auto-reload gives a periodic tick. It sits beside `up_counter` in the PUF timing/sequencing logic, where it serves as the timeout and measurement-window generator.

## Interface
- `WIDTH`, 8: counter, start-value and reload-register width.
- `clk`  input  1  rising-edge clock; single clock domain.
- `reset`  input  1  synchronous, active-low reset; sampled on the `clk` rising edge; 0 = reset.
- `enable`  input  1  count enable; while 0, all state holds.
- `load`  input  1  load strobe; captures `in` into the counter and reload register.
- `in`  input  WIDTH  start value.
- `auto_reload`  input  1  1 = restart from the reload register after reaching zero.
- `out`  output  WIDTH  current count (registered).
- `zero`  output  1  level; 1 whenever `out == 0`.
- `tc`  output  1  one-cycle pulse in the cycle `out` first becomes 0 by counting.
- `busy`  output  1  1 while in COUNT state.

## Operation
- States: IDLE, COUNT, DONE.
- Reset (`reset`=0 at a rising edge) forces:
  - `out`=0, reload register=0, state IDLE.
  - `tc`=0, `busy`=0, `zero`=1.
- Priority at each edge: reset > load > counting.
- `load`=1 in any state:
  - `out`<=`in` and reload<=`in`.
  - Next state is COUNT if `in`≠0, else IDLE.
  - `tc`=0. Load does not require `enable`.
- IDLE: `out` holds and `enable` is ignored. The block leaves IDLE only on load.
- COUNT with `enable`=1:
  - If `out`>1: `out`<=`out`−1.
  - If `out`==1: `out`<=0, `tc`<=1, next state DONE.
- COUNT with `enable`=0: hold; `tc`=0.
- DONE:
  - `out` holds at 0; `tc` returns to 0.
  - If `enable`=1 and `auto_reload`=1: `out`<=reload, next state COUNT. A reload value of 0 is impossible here, because loads of 0 go to IDLE.
  - Otherwise DONE holds until load or reset.
- `auto_reload` is sampled only in DONE. Changing it mid-count has no effect until zero is reached.
- No wrap-around. The counter never decrements below 0 and never underflows to all-ones.
- Arithmetic is unsigned WIDTH-bit. The maximum start value is 2^WIDTH−1.
- Load and terminal count in the same cycle: load wins; `tc` stays 0; `out`=`in`.
- Reset mid-count: state is discarded at that edge, and no `tc` is produced.

## Timing
- All outputs are registered, except `zero`, which is combinational from `out`.
- Load latency is 1 cycle: `out` shows `in` after the load edge.
- From load of N (N≥1) with `enable` held at 1:
  - `out` steps N, N−1, …, 1, 0 on consecutive edges.
  - `tc`=1 in the same cycle `out`=0, i.e. N edges after the load edge.
- Auto-reload period is N+1 enabled cycles: one cycle sits in DONE at 0, then `out`=N again.
- `enable` gaps stretch timing one-for-one; `tc` never lasts more than 1 cycle.
- `busy` is 1 from the cycle after a nonzero load through the cycle before `out`=0.

## Structure
- Shared package `down_counter_pkg`:
  - `typedef enum logic [1:0] {IDLE, COUNT, DONE} dc_state_t`.
  - `DC_DEFAULT_WIDTH = 8`.
- Single module; no sub-module. The state register, count register, reload register and `tc` flop all live in one `always_ff`. Next-state logic sits in one `always_comb`.

## Test plan
- **Reset then hold:** `reset`=0 for 2 edges, `in`=8'hFA, `enable`=1 -> `out`=0, `zero`=1, `tc`=0, `busy`=0, and the state stays IDLE with no counting.
- **Basic count:** load 8'h05, then `enable`=1 -> `out`=5,4,3,2,1,0. `tc`=1 only in the cycle `out`=0. After that, `out` stays 0 for 10 further cycles with `auto_reload`=0.
- **Enable gap:**
  - Load 8'h0A; count to 7; drop `enable` for 3 cycles -> `out` holds 7.
  - Re-enable -> `tc` arrives 3 cycles later than ungated.
- **Auto-reload:** load 8'h03 with `auto_reload`=1 -> `out` = 3,2,1,0,3,2,1,0…, with a `tc` pulse every 4 cycles.
- **Collisions:**
  - Load 8'hFA on the edge where `out` would go 1->0 -> `out`=8'hFA and `tc`=0.
  - Load 8'h00 -> state IDLE, `zero`=1, and no `tc`.
- **Reset mid-count:** load 8'hFF, count 20 cycles, then `reset`=0 for 1 edge -> `out`=0, state IDLE, no `tc`. Counting resumes only after a new load.
